multi_char_read_axil: RTL and testbench
=======================================

# multi_char_read_axil

AXI4-Lite slave that lets the Cortex-M3 stage character glyphs of parametrised width and queue them, tagged with a slot index, into a FIFO that drains to the display pipeline over a valid/ready stream. It sits on the M3 AXI peripheral interconnect next to the display logic. It generalises the single-character 40-bit reader to configurable glyph width, slot count and queue depth, with status reporting and error responses.

## Interface
- CHAR_BITS, 40: glyph width; legal range 33..64.
- NUM_CHARS, 16: slot count; legal range 1..256. Slot index width IDX_W = max(1, clog2(NUM_CHARS)).
- FIFO_DEPTH, 4: output queue depth; must be a power of two, 2..64.

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_areset  in  1  asynchronous, active-high reset.
- s00_axi_awaddr / awvalid / awready  in/in/out  4/1/1  write address channel.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr / arvalid / arready  in/in/out  4/1/1  read address channel.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.
- char_data  out  CHAR_BITS  glyph at FIFO head.
- char_idx  out  IDX_W  slot index at FIFO head.
- char_valid  out  1  FIFO not empty.
- char_ready  in  1  display consumer accepts the head entry.
- irq  out  1  drain interrupt; present only with MCR_IRQ_EN.

## Operation
- Register map uses word addresses; awaddr/araddr [1:0] are ignored.
  - 0x0 GLYPH_LO: R/W, holds glyph bits [31:0].
  - 0x4 GLYPH_HI: R/W, holds glyph bits [CHAR_BITS-1:32]. Unused upper bits read 0.
  - 0x8 CTRL: W only. [IDX_W-1:0] is the slot index; bit31 = PUSH. Reads return 0.
  - 0xC STATUS: R. bit0 = fifo_empty, bit1 = fifo_full, bit2 = overflow (sticky), bit3 = idx_err (sticky), bit4 = irq_pend, [15:8] = fifo count. Writing 1 to bit2, bit3 or bit4 clears that bit.
- wstrb applies per byte to GLYPH_LO and GLYPH_HI. A CTRL write with wstrb[3]=0 does not push.
- A CTRL write with PUSH=1 and index < NUM_CHARS enqueues {GLYPH_HI:GLYPH_LO, index}. Response is OKAY.
- A push with index >= NUM_CHARS is not enqueued. It sets idx_err and returns SLVERR (2'b10).
- A push while the FIFO is full is not enqueued. It sets overflow and returns SLVERR. The glyph registers are unchanged in both error cases.
- A stream transfer occurs when char_valid && char_ready. The FIFO pops on that transfer.

## Timing
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, glyph registers 0, FIFO empty, char_data/char_idx 0, all sticky bits 0, irq 0.
- Write channel: when awvalid && wvalid && !bvalid, awready and wready pulse high together for one cycle. The register update and any enqueue happen on that edge. bvalid rises the next cycle and holds until bready.
- Read channel: when arvalid && !rvalid, arready pulses for one cycle. rvalid and rdata are registered the next cycle and held until rready.
- Read and write are accepted in the same cycle independently. A STATUS read in the push cycle returns the pre-push value.
- FIFO latency: a pushed entry appears on char_valid the cycle after the W handshake.
- Push and pop in the same cycle on a full FIFO: the push is rejected, because the full check uses the registered state. On a non-empty, non-full FIFO, count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits wide.
- char_data and char_idx stay stable while char_valid && !char_ready.
- Asserting reset mid-transaction immediately drops every valid. In-flight AXI transfers and queued entries are discarded.

## Configuration
- MCR_IRQ_EN defined:
  - irq_pend sets on the cycle the FIFO goes from 1 entry to 0 through a pop.
  - irq = irq_pend, registered. It is cleared by a STATUS write with bit4 = 1. A set and a clear in the same cycle leave irq_pend set.
- MCR_IRQ_EN undefined:
  - The irq port is absent. STATUS bit4 reads 0 and writes to it are ignored.

## Test plan
- Glyph push: write GLYPH_LO=0x89ABCDEF, GLYPH_HI=0x67, CTRL=0x8000_0005 -> char_valid one cycle after the W handshake, char_data=0x67_89ABCDEF, char_idx=5, bresp=OKAY.
- Strobes: GLYPH_LO=0xFFFFFFFF, then a write of 0x00000000 with wstrb=4'b0010 -> read GLYPH_LO=0xFFFF00FF.
- Full FIFO: hold char_ready=0 and do 5 pushes with FIFO_DEPTH=4 -> the 5th gets SLVERR, STATUS=0x0406 (count 4, full, overflow). Release char_ready -> 4 entries drain in push order.
- Index error: CTRL=0x8000_0010 with NUM_CHARS=16 -> SLVERR, STATUS bit3=1, no enqueue. Write 0x8 to STATUS -> bit3 clears.
- Reset mid-stream: 3 entries queued, assert s00_axi_areset for 2 cycles -> char_valid=0 and STATUS reads 0x0001 after release.
- MCR_IRQ_EN: push 1 entry, pop it -> irq=1 within 2 cycles. STATUS write of 0x10 -> irq=0 the next cycle.

Source files
------------

// File: rtl/multi_char_read_axil.sv
// ============================================================================
// multi_char_read_axil
// ----------------------------------------------------------------------------
// AXI4-Lite slave for the Cortex-M3 peripheral interconnect. Software stages a
// glyph of CHAR_BITS bits in two 32-bit registers, then writes a slot index
// with the PUSH bit to queue {glyph, index} into a small FIFO. The FIFO drains
// to the display pipeline over a valid/ready stream.
//
// Register map (word addresses; address bits [1:0] are ignored):
//   0x0 GLYPH_LO  R/W  glyph bits [31:0], byte strobes honoured
//   0x4 GLYPH_HI  R/W  glyph bits [CHAR_BITS-1:32], unused upper bits read 0
//   0x8 CTRL      W    [IDX_W-1:0] slot index, bit31 PUSH (needs wstrb[3])
//   0xC STATUS    R/W1C  bit0 empty, bit1 full, bit2 overflow, bit3 idx_err,
//                      bit4 irq_pend, [15:8] fifo count
//
// Parameters:
//   CHAR_BITS   glyph width, 33..64
//   NUM_CHARS   number of slots, 1..256
//   FIFO_DEPTH  output queue depth, power of two, 2..64
//
// Ports:
//   s00_axi_aclk / s00_axi_areset   clock, asynchronous active-high reset
//   s00_axi_aw* / w* / b*           AXI4-Lite write address/data/response
//   s00_axi_ar* / r*                AXI4-Lite read address/data
//   char_data / char_idx            FIFO head entry (0 while empty)
//   char_valid / char_ready         display stream handshake
//   irq                             drain interrupt (only with MCR_IRQ_EN)
//
// Optional feature: define MCR_IRQ_EN to get the irq port and the irq_pend
// status bit, which sets whenever a pop empties the FIFO.
// ============================================================================
module multi_char_read_axil #(
    parameter  int CHAR_BITS  = 40,
    parameter  int NUM_CHARS  = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_areset,
    // write address channel
    input  logic [3:0]           s00_axi_awaddr,
    input  logic                 s00_axi_awvalid,
    output logic                 s00_axi_awready,
    // write data channel
    input  logic [31:0]          s00_axi_wdata,
    input  logic [3:0]           s00_axi_wstrb,
    input  logic                 s00_axi_wvalid,
    output logic                 s00_axi_wready,
    // write response channel
    output logic [1:0]           s00_axi_bresp,
    output logic                 s00_axi_bvalid,
    input  logic                 s00_axi_bready,
    // read address channel
    input  logic [3:0]           s00_axi_araddr,
    input  logic                 s00_axi_arvalid,
    output logic                 s00_axi_arready,
    // read data channel
    output logic [31:0]          s00_axi_rdata,
    output logic [1:0]           s00_axi_rresp,
    output logic                 s00_axi_rvalid,
    input  logic                 s00_axi_rready,
    // display stream
    output logic [CHAR_BITS-1:0] char_data,
    output logic [IDX_W-1:0]     char_idx,
    output logic                 char_valid,
    input  logic                 char_ready
`ifdef MCR_IRQ_EN
    ,
    output logic                 irq
`endif
);

    // ------------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------------
    localparam int HI_W  = CHAR_BITS - 32;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = CHAR_BITS + IDX_W;

    // Bits of GLYPH_HI that actually exist for this glyph width.
    localparam logic [31:0] HI_MASK = 32'hFFFF_FFFF >> (64 - CHAR_BITS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_GLYPH_LO = 2'd0,
        REG_GLYPH_HI = 2'd1,
        REG_CTRL     = 2'd2,
        REG_STATUS   = 2'd3
    } reg_sel_e;

    // Byte-lane merge for strobed register writes.
    function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      glyph_lo;
    logic [31:0]      glyph_hi;          // bits above HI_W are always 0
    logic             overflow;
    logic             idx_err;
    logic             irq_bit;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // ------------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------------
    logic       wr_fire;
    reg_sel_e   wr_sel;
    logic       push_req;
    logic       idx_bad;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_ok;
    logic       push_ovf;
    logic       push_idx_err;
    logic       status_wr;
    logic       pop;

    // awready and wready are always raised together, so a single AND of the
    // four signals marks the accepting edge.
    assign wr_fire   = s00_axi_awready && s00_axi_awvalid &&
                       s00_axi_wready  && s00_axi_wvalid;
    assign wr_sel    = reg_sel_e'(s00_axi_awaddr[3:2]);
    assign status_wr = wr_fire && (wr_sel == REG_STATUS);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // The index range check looks at all of bits [30:0], so a value such as
    // 0x10 with 16 slots is rejected instead of silently aliasing to slot 0.
    assign idx_bad      = {1'b0, s00_axi_wdata[30:0]} >= 32'(NUM_CHARS);
    assign push_req     = wr_fire && (wr_sel == REG_CTRL) &&
                          s00_axi_wstrb[3] && s00_axi_wdata[31];
    assign push_idx_err = push_req && idx_bad;
    // Full is the registered state: a pop in the same cycle does not make
    // room for this push.
    assign push_ovf     = push_req && !idx_bad && fifo_full;
    assign push_ok      = push_req && !idx_bad && !fifo_full;

    assign pop = char_valid && char_ready;

    // ------------------------------------------------------------------------
    // AXI write channel and glyph registers
    // ------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all state
    // updates on an edge see the pre-edge values of each other.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            glyph_lo        <= '0;
            glyph_hi        <= '0;
        end else begin
            // One-cycle accept pulse; bvalid blocks a new accept until the
            // response has been taken.
            if (!s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid &&
                !s00_axi_bvalid) begin
                s00_axi_awready <= 1'b1;
                s00_axi_wready  <= 1'b1;
            end else begin
                s00_axi_awready <= 1'b0;
                s00_axi_wready  <= 1'b0;
            end

            if (wr_fire) begin
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= (push_idx_err || push_ovf) ? RESP_SLVERR
                                                             : RESP_OKAY;
                case (wr_sel)
                    REG_GLYPH_LO: glyph_lo <= apply_strobe(glyph_lo, s00_axi_wdata,
                                                           s00_axi_wstrb);
                    REG_GLYPH_HI: glyph_hi <= apply_strobe(glyph_hi, s00_axi_wdata,
                                                           s00_axi_wstrb) & HI_MASK;
                    default: ;
                endcase
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky status bits (write-1-to-clear; a set wins over a clear)
    // ------------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            overflow <= 1'b0;
            idx_err  <= 1'b0;
        end else begin
            if (push_ovf)                          overflow <= 1'b1;
            else if (status_wr && s00_axi_wdata[2]) overflow <= 1'b0;

            if (push_idx_err)                      idx_err <= 1'b1;
            else if (status_wr && s00_axi_wdata[3]) idx_err <= 1'b0;
        end
    end

`ifdef MCR_IRQ_EN
    logic irq_pend;
    logic drain_to_empty;

    // The FIFO goes from one entry to none only when a pop is not matched
    // by a push in the same cycle.
    assign drain_to_empty = pop && (count == CNT_W'(1)) && !push_ok;

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            irq_pend <= 1'b0;
        end else if (drain_to_empty) begin
            irq_pend <= 1'b1;
        end else if (status_wr && s00_axi_wdata[4]) begin
            irq_pend <= 1'b0;
        end
    end

    assign irq_bit = irq_pend;
    assign irq     = irq_pend;
`else
    assign irq_bit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // AXI read channel
    // ------------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    assign status_word = {16'h0000, 8'(count), 3'b000,
                          irq_bit, idx_err, overflow, fifo_full, fifo_empty};

    // NOTE: the default assignment up front keeps this block purely
    // combinational; without it unlisted selects would infer a latch.
    always_comb begin
        rd_mux = 32'h0000_0000;
        case (reg_sel_e'(s00_axi_araddr[3:2]))
            REG_GLYPH_LO: rd_mux = glyph_lo;
            REG_GLYPH_HI: rd_mux = glyph_hi;
            REG_CTRL:     rd_mux = 32'h0000_0000;
            REG_STATUS:   rd_mux = status_word;
            default:      rd_mux = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            if (!s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid) begin
                s00_axi_arready <= 1'b1;
            end else begin
                s00_axi_arready <= 1'b0;
            end

            // Data is captured from pre-edge state, so a STATUS read that
            // coincides with a push reports the value before the push.
            if (s00_axi_arready && s00_axi_arvalid) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    assign s00_axi_rresp = RESP_OKAY;

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count,
    // and the head outputs are forced to 0 while the FIFO is empty.
    always_ff @(posedge s00_axi_aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {glyph_hi[HI_W-1:0], glyph_lo,
                            s00_axi_wdata[IDX_W-1:0]};
        end
    end

    // A push never lands on rd_ptr while the FIFO is non-empty (that would
    // need a full FIFO, which rejects the push), so the head stays stable
    // while the consumer stalls.
    logic [ENT_W-1:0] head;
    assign head       = mem[rd_ptr];
    assign char_valid = !fifo_empty;
    assign char_data  = fifo_empty ? '0 : head[ENT_W-1:IDX_W];
    assign char_idx   = fifo_empty ? '0 : head[IDX_W-1:0];

    // Word-address LSBs carry no meaning in this register map.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_multi_char_read_axil.sv
// ============================================================================
// tb_multi_char_read_axil
// ----------------------------------------------------------------------------
// Self-checking bench for multi_char_read_axil with default parameters
// (CHAR_BITS=40, NUM_CHARS=16, FIFO_DEPTH=4). Expected stream entries are
// pushed into a scoreboard queue when a push is issued and compared by a
// monitor when the DUT transfers them. Scenario tasks do inline comparisons.
// Works with or without MCR_IRQ_EN defined.
// ============================================================================
module tb_multi_char_read_axil;

    localparam int CB = 40;
    localparam int NC = 16;
    localparam int FD = 4;
    localparam int IW = 4;

`ifdef MCR_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam logic [3:0] A_LO   = 4'h0;
    localparam logic [3:0] A_HI   = 4'h4;
    localparam logic [3:0] A_CTRL = 4'h8;
    localparam logic [3:0] A_STAT = 4'hC;

    logic          clk;
    logic          rst;
    logic [3:0]    awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [3:0]    araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [CB-1:0] char_data;
    logic [IW-1:0] char_idx;
    logic          char_valid;
    logic          char_ready;
`ifdef MCR_IRQ_EN
    logic          irq;
`endif

    int n_total = 0;
    int n_pass  = 0;

    logic [CB+IW-1:0] sb[$];
    logic             cv_pre;
    logic             cv_post;

    multi_char_read_axil dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .char_data       (char_data),
        .char_idx        (char_idx),
        .char_valid      (char_valid),
        .char_ready      (char_ready)
`ifdef MCR_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream monitor: a transfer happens on the next rising edge whenever
    // valid and ready are both high at the falling edge.
    always @(negedge clk) begin
        logic [CB+IW-1:0] exp_ent;
        if (!rst && char_valid && char_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL stream_unexpected got data=%h idx=%0d, expected no entry",
                         char_data, char_idx);
            end else begin
                exp_ent = sb.pop_front();
                if ({char_data, char_idx} !== exp_ent) begin
                    $display("FAIL stream_entry got data=%h idx=%0d, expected data=%h idx=%0d",
                             char_data, char_idx, exp_ent[CB+IW-1:IW], exp_ent[IW-1:0]);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bus drivers
    // ------------------------------------------------------------------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit got;
        resp = 2'b11;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin
                got = 1'b1;
                cv_pre = char_valid;
                break;
            end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        cv_post = char_valid;
        if (!got) begin
            n_total++;
            $display("FAIL axi_write_accept_timeout addr=%h", addr);
            bready = 1'b0;
            return;
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin
                got = 1'b1;
                resp = bresp;
                break;
            end
        end
        @(posedge clk); #1;
        bready = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL axi_write_bvalid_timeout addr=%h", addr);
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit got;
        data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL axi_read_accept_timeout addr=%h", addr);
            rready = 1'b0;
            return;
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                got = 1'b1;
                data = rdata;
                break;
            end
        end
        @(posedge clk); #1;
        rready = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL axi_read_rvalid_timeout addr=%h", addr);
        end
    endtask

    task automatic clear_status();
        logic [1:0] r;
        axi_write(A_STAT, 32'h0000_001C, 4'hF, r);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!char_valid) begin
                done = 1'b1;
                break;
            end
        end
        n_total++;
        if (!done || sb.size() != 0) begin
            $display("FAIL drain got char_valid=%0b pending=%0d, expected 0 and 0",
                     char_valid, sb.size());
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
             char_valid, char_data, char_idx} !== '0) begin
            $display("FAIL reset_outputs got aw=%b w=%b b=%b bresp=%b ar=%b r=%b rresp=%b rdata=%h cv=%b cd=%h ci=%h, expected all 0",
                     awready, wready, bvalid, bresp, arready, rvalid, rresp,
                     rdata, char_valid, char_data, char_idx);
        end else begin
            n_pass++;
        end
`ifdef MCR_IRQ_EN
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq got %b, expected 0", irq);
        else n_pass++;
`endif
        rst = 1'b0;
        axi_read(A_STAT, d);
        n_total++;
        if (d !== 32'h0000_0001) $display("FAIL reset_status got %h, expected 00000001", d);
        else n_pass++;
        axi_read(A_LO, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL reset_glyph_lo got %h, expected 00000000", d);
        else n_pass++;
    endtask

    task automatic test_glyph_push();
        logic [1:0] r;
        char_ready = 1'b0;
        axi_write(A_LO, 32'h89AB_CDEF, 4'hF, r);
        axi_write(A_HI, 32'h0000_0067, 4'hF, r);
        sb.push_back({40'h67_89AB_CDEF, 4'd5});
        axi_write(A_CTRL, 32'h8000_0005, 4'hF, r);
        n_total++;
        if (r !== 2'b00) $display("FAIL push_bresp got %b, expected 00", r);
        else n_pass++;
        n_total++;
        if (cv_pre !== 1'b0 || cv_post !== 1'b1)
            $display("FAIL push_latency got before=%b after=%b, expected 0 1", cv_pre, cv_post);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (char_data !== 40'h67_89AB_CDEF || char_idx !== 4'd5)
            $display("FAIL push_head_stable got data=%h idx=%0d, expected 6789abcdef 5",
                     char_data, char_idx);
        else n_pass++;
        char_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_strobes();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(A_LO, 32'hFFFF_FFFF, 4'hF, r);
        axi_write(A_LO, 32'h0000_0000, 4'b0010, r);
        axi_read(A_LO, d);
        n_total++;
        if (d !== 32'hFFFF_00FF) $display("FAIL strobe_lo got %h, expected ffff00ff", d);
        else n_pass++;
        axi_write(A_HI, 32'hFFFF_FFFF, 4'hF, r);
        axi_read(A_HI, d);
        n_total++;
        if (d !== 32'h0000_00FF) $display("FAIL hi_mask got %h, expected 000000ff", d);
        else n_pass++;
        axi_write(A_HI, 32'h0000_0000, 4'b1110, r);
        axi_read(A_HI, d);
        n_total++;
        if (d !== 32'h0000_00FF) $display("FAIL strobe_hi got %h, expected 000000ff", d);
        else n_pass++;
        axi_read(A_CTRL, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL ctrl_read got %h, expected 00000000", d);
        else n_pass++;
    endtask

    task automatic test_idx_err();
        logic [1:0]  r;
        logic [31:0] d;
        clear_status();
        char_ready = 1'b0;
        axi_write(A_CTRL, 32'h8000_0010, 4'hF, r);
        n_total++;
        if (r !== 2'b10) $display("FAIL idx_err_bresp got %b, expected 10", r);
        else n_pass++;
        axi_read(A_STAT, d);
        n_total++;
        if (d !== 32'h0000_0009) $display("FAIL idx_err_status got %h, expected 00000009", d);
        else n_pass++;
        axi_write(A_STAT, 32'h0000_0008, 4'hF, r);
        axi_read(A_STAT, d);
        n_total++;
        if (d !== 32'h0000_0001) $display("FAIL idx_err_clear got %h, expected 00000001", d);
        else n_pass++;
        // PUSH without the top byte strobe is not a push.
        axi_write(A_CTRL, 32'h8000_0003, 4'b0111, r);
        n_total++;
        if (r !== 2'b00 || char_valid !== 1'b0)
            $display("FAIL ctrl_no_strobe got bresp=%b cv=%b, expected 00 0", r, char_valid);
        else n_pass++;
        // Highest legal slot index.
        axi_write(A_LO, 32'h1234_5678, 4'hF, r);
        axi_write(A_HI, 32'h0000_009A, 4'hF, r);
        sb.push_back({40'h9A_1234_5678, 4'd15});
        axi_write(A_CTRL, 32'h8000_000F, 4'hF, r);
        n_total++;
        if (r !== 2'b00) $display("FAIL idx_max_bresp got %b, expected 00", r);
        else n_pass++;
        char_ready = 1'b1;
        wait_drain();
        clear_status();
    endtask

    task automatic test_full_fifo();
        logic [1:0]  r;
        logic [1:0]  exp_r;
        logic [31:0] d;
        int          model_cnt;
        clear_status();
        char_ready = 1'b0;
        model_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            axi_write(A_LO, 32'h1000_0000 + 32'(k), 4'hF, r);
            axi_write(A_HI, 32'(k + 8'hA0), 4'hF, r);
            if (model_cnt < FD) begin
                sb.push_back({8'(k + 8'hA0), 32'h1000_0000 + 32'(k), 4'(k + 1)});
                model_cnt++;
                exp_r = 2'b00;
            end else begin
                exp_r = 2'b10;
            end
            axi_write(A_CTRL, 32'h8000_0000 | 32'(k + 1), 4'hF, r);
            n_total++;
            if (r !== exp_r) $display("FAIL full_push%0d_bresp got %b, expected %b", k, r, exp_r);
            else n_pass++;
        end
        axi_read(A_STAT, d);
        n_total++;
        if (d !== 32'h0000_0406) $display("FAIL full_status got %h, expected 00000406", d);
        else n_pass++;
        char_ready = 1'b1;
        wait_drain();
        axi_read(A_STAT, d);
        n_total++;
        if (d !== (32'h0000_0005 | (IRQ_ON ? 32'h10 : 32'h0)))
            $display("FAIL drained_status got %h, expected %h",
                     d, 32'h0000_0005 | (IRQ_ON ? 32'h10 : 32'h0));
        else n_pass++;
        clear_status();
        axi_read(A_STAT, d);
        n_total++;
        if (d !== 32'h0000_0001) $display("FAIL status_w1c got %h, expected 00000001", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  r;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  idx;
        int          errs;
        char_ready = 1'b1;
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            lo  = $urandom;
            hi  = $urandom;
            idx = 4'($urandom_range(0, NC - 1));
            axi_write(A_LO, lo, 4'hF, r);
            axi_write(A_HI, hi, 4'hF, r);
            sb.push_back({hi[7:0], lo, idx});
            axi_write(A_CTRL, 32'h8000_0000 | 32'(idx), 4'hF, r);
            if (r !== 2'b00) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL b2b_bresp got %0d error responses, expected 0", errs);
        else n_pass++;
        wait_drain();
        clear_status();
    endtask

    task automatic test_reset_mid_stream();
        logic [1:0]  r;
        logic [31:0] d;
        char_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            axi_write(A_LO, 32'hCAFE_0000 + 32'(k), 4'hF, r);
            axi_write(A_CTRL, 32'h8000_0000 | 32'(k), 4'hF, r);
        end
        n_total++;
        if (char_valid !== 1'b1) $display("FAIL pre_reset_valid got %b, expected 1", char_valid);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        #1;
        n_total++;
        if (char_valid !== 1'b0) $display("FAIL reset_async_valid got %b, expected 0", char_valid);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        axi_read(A_STAT, d);
        n_total++;
        if (d !== 32'h0000_0001 || char_valid !== 1'b0)
            $display("FAIL reset_mid_status got %h cv=%b, expected 00000001 0", d, char_valid);
        else n_pass++;
    endtask

`ifdef MCR_IRQ_EN
    task automatic test_irq();
        logic [1:0]  r;
        logic [31:0] d;
        bit          got;
        clear_status();
        char_ready = 1'b0;
        axi_write(A_LO, 32'h0BAD_F00D, 4'hF, r);
        sb.push_back({8'h00, 32'h0BAD_F00D, 4'd3});
        axi_write(A_CTRL, 32'h8000_0003, 4'hF, r);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_before_pop got %b, expected 0", irq);
        else n_pass++;
        @(posedge clk); #1;
        char_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (irq) begin
                got = 1'b1;
                break;
            end
        end
        n_total++;
        if (!got) $display("FAIL irq_rise got 0, expected 1 within 2 cycles");
        else n_pass++;
        axi_write(A_STAT, 32'h0000_0010, 4'hF, r);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_clear got %b, expected 0", irq);
        else n_pass++;
        axi_read(A_STAT, d);
        n_total++;
        if (d !== 32'h0000_0001) $display("FAIL irq_status got %h, expected 00000001", d);
        else n_pass++;
    endtask
`endif

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        char_ready = 1'b0;
        cv_pre = 1'b0; cv_post = 1'b0;

        test_reset();
        test_glyph_push();
        test_strobes();
        test_idx_err();
        test_full_fifo();
        test_back_to_back();
        test_reset_mid_stream();
`ifdef MCR_IRQ_EN
        test_irq();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
